// File: rtl/serial_addsub_ctrl.sv
// Bit-serial adder/subtractor with IDLE/RUN/DONE control.
// One full-adder cell and a carry register process one bit per RUN cycle,
// LSB first; subtraction is a + ~b + 1 with the +1 preloaded into the carry.
module serial_addsub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic            sub_q, carry_q, cout_q, ovf_q;
  logic [CntW-1:0] cnt_q;

  logic bit_a, bit_b, fa_sum, fa_cout;
  logic accept, last_bit;

  // Single full-adder cell; B is inverted in subtract mode.
  assign bit_a   = a_q[0];
  assign bit_b   = b_q[0] ^ sub_q;
  assign fa_sum  = bit_a ^ bit_b ^ carry_q;
  assign fa_cout = (bit_a & bit_b) | (carry_q & (bit_a ^ bit_b));

  assign accept   = (state_q == StIdle) && start;
  assign last_bit = (state_q == StRun) && (cnt_q == LastIdx);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_bit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Operand capture, serial datapath and result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      sub_q   <= sub;
      cnt_q   <= '0;
      carry_q <= sub;
    end else if (state_q == StRun) begin
      a_q        <= {1'b0, a_q[WIDTH-1:1]};
      b_q        <= {1'b0, b_q[WIDTH-1:1]};
      s_q[cnt_q] <= fa_sum;
      carry_q    <= fa_cout;
      if (last_bit) begin
        // carry_q here is the carry into the MSB.
        cout_q <= fa_cout;
        ovf_q  <= carry_q ^ fa_cout;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Status decodes straight from state so reset clears them immediately.
  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
    s    = s_q;
    cout = cout_q;
    ovf  = ovf_q;
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed bench for serial_addsub_ctrl at WIDTH=8.
module tb_serial_addsub_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, cout, ovf;
  logic [WIDTH-1:0] s;

  int vectors    = 0;
  int miscompares = 0;

  serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Run one operation; optionally pulse start with new operands at RUN cycle glitch.
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic tsub, input logic [7:0] es, input logic ec,
                        input logic eo, input int glitch);
    @(negedge clk);
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    sub   = tsub;
    @(negedge clk);
    start = 1'b0;
    // Operands change after acceptance; must not matter.
    a     = ~ta;
    b     = 8'hA5;
    sub   = ~tsub;
    check({tag, "_busy1"}, {31'd0, busy}, 32'd1);
    for (int i = 2; i <= WIDTH; i++) begin
      @(negedge clk);
      check({tag, "_busy"}, {30'd0, busy, done}, 32'd2);
      if (i == glitch) begin
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        sub   = 1'b0;
      end else if (i == glitch + 1) begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done"}, {30'd0, busy, done}, 32'd1);
    check({tag, "_s"}, {24'd0, s}, {24'd0, es});
    check({tag, "_flags"}, {30'd0, cout, ovf}, {30'd0, ec, eo});
    @(negedge clk);
    check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    check({tag, "_hold"}, {22'd0, s, cout, ovf}, {22'd0, es, ec, eo});
  endtask

  initial begin
    int n;
    int p;
    logic idle_seen;

    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    #1;
    check("reset_state", {21'd0, busy, done, s, cout, ovf}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("add_5a_33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1, -1);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, -1);
    run_op("sub_10_20", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, -1);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, -1);
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, -1);
    run_op("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, -1);
    run_op("sub_05_05", 8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0, -1);
    run_op("sub_00_01", 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, -1);

    // Restart attempt at RUN cycle 3 is ignored.
    run_op("restart_ign", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 3);

    // Reset in the middle of RUN aborts with no done pulse.
    @(negedge clk);
    start = 1'b1;
    a     = 8'h5A;
    b     = 8'h33;
    sub   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", {21'd0, busy, done, s, cout, ovf}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_nodone", {30'd0, busy, done}, 32'd0);
    end
    rst_n = 1'b1;
    run_op("post_rst_add", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, -1);

    // Start held high: back-to-back operations with one IDLE cycle between.
    @(negedge clk);
    start = 1'b1;
    a     = 8'h7F;
    b     = 8'h01;
    sub   = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_done", {31'd0, done}, 32'd1);
    check("b2b_first_s", {24'd0, s}, 32'h80);
    p = 0;
    idle_seen = 1'b0;
    do begin
      @(negedge clk);
      p++;
      if (p == 1) idle_seen = (busy === 1'b0) && (done === 1'b0);
    end while (done !== 1'b1 && p < 40);
    check("b2b_idle_gap", {31'd0, idle_seen}, 32'd1);
    check("b2b_period", p, WIDTH + 2);
    start = 1'b0;
    @(negedge clk);
    check("b2b_stop", {30'd0, busy, done}, 32'd0);
    repeat (2) @(negedge clk);
    check("b2b_stay_idle", {30'd0, busy, done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_addsub_ctrl.md
SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (WIDTH >= 2).
REQ-002 clk  input  1  single system clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 sub  input  1  0 = add (a+b), 1 = subtract (a-b); captured with start.
REQ-006 a  input  WIDTH  operand A, two's complement or unsigned; captured with start.
REQ-007 b  input  WIDTH  operand B; captured with start.
REQ-008 busy  output  1  high while an operation is in progress (RUN).
REQ-009 done  output  1  one-cycle pulse, result valid.
REQ-010 s  output  WIDTH  sum/difference.
REQ-011 cout  output  1  carry out of MSB (sub: 1 = no borrow).
REQ-012 ovf  output  1  signed overflow flag.

Function
REQ-013 The block SHALL compute the result bit-serially, LSB first, using exactly one 1-bit full-adder cell (s = a^b^cin, cout = a&b | cin&(a^b)) plus a 1-bit carry register.
REQ-014 FSM states SHALL be IDLE, RUN, DONE; IDLE->RUN on rising edge with start=1; RUN->DONE after bit WIDTH-1 processed; DONE->IDLE unconditionally next edge.
REQ-015 On the accepting edge the block SHALL latch a, b, sub into internal shift registers, set bit counter to 0, and load carry register with sub.
REQ-016 In subtract mode each B bit SHALL be inverted before the full adder (a + ~b + 1).
REQ-017 Each RUN edge SHALL process exactly one bit index i (0..WIDTH-1), write result bit into s[i], update carry register, increment counter.
REQ-018 Counter SHALL be ceil(log2(WIDTH)) bits wide minimum and SHALL NOT wrap during RUN; RUN lasts exactly WIDTH cycles.
REQ-019 On the edge processing bit WIDTH-1: cout <= full-adder carry out; ovf <= carry into MSB XOR carry out of MSB.
REQ-020 Latency: start accepted at edge k -> done high during cycle after edge k+WIDTH, for exactly one cycle.
REQ-021 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; never both high.
REQ-022 start SHALL be ignored in RUN and DONE (no restart, no operand change); it is only honoured in IDLE.
REQ-023 Operand input changes after acceptance SHALL NOT affect the running operation.
REQ-024 s, cout, ovf SHALL hold their final values from DONE through IDLE until the next accepted start; during RUN s contents are partial and unspecified for bits not yet processed.
REQ-025 Unsigned add: cout = true carry; unsigned sub: cout=0 indicates borrow (a < b).

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, counter 0, carry 0, busy 0, done 0, s = 0, cout 0, ovf 0, independent of clk.
REQ-027 Reset asserted mid-RUN SHALL abort the operation with no done pulse; first start after rst_n release SHALL be accepted normally.
REQ-028 start high during the edge rst_n deasserts SHALL only be accepted on a subsequent edge with rst_n high.

Verification (WIDTH=8)
REQ-029 add a=8'h5A b=8'h33 -> after 8 RUN cycles done pulse, s=8'h8D, cout=0, ovf=1.
REQ-030 add a=8'hFF b=8'h01 -> s=8'h00, cout=1, ovf=0.
REQ-031 sub a=8'h10 b=8'h20 -> s=8'hF0, cout=0 (borrow), ovf=0; sub a=8'h80 b=8'h01 -> s=8'h7F, cout=1, ovf=1.
REQ-032 start pulsed again at RUN cycle 3 with different operands -> ignored; first result unchanged, done at original cycle, busy duration exactly 8 cycles.
REQ-033 rst_n low at RUN cycle 4 -> all outputs 0 asynchronously, no done; new add 8'h01+8'h01 after release -> s=8'h02, cout=0, ovf=0.
REQ-034 start held high continuously -> back-to-back operations, IDLE visible one cycle between DONE and next RUN, done period = WIDTH+2 cycles.
